// File: rtl/alu_md_pkg.sv
// ---------------------------------------------------------------------------
// alu_md_pkg
// Shared definitions for the iterative RV32M multiply/divide unit:
//   - funct3 operation encodings
//   - FSM state type (IDLE / CALC / DONE)
//   - operation-class helpers (operand signedness, divide/remainder, high half)
//   - width-parametrised two's-complement negate
// ---------------------------------------------------------------------------
package alu_md_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Widest vector the negate helper handles; covers the 2*XLEN product
    // for XLEN up to 64.
    localparam int unsigned NEG_MAX_W = 128;

    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_div(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

    function automatic logic is_rem(input logic [2:0] f3);
        return (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

    function automatic logic ret_high(input logic [2:0] f3);
        return (f3 != F3_MUL) && !is_div(f3);
    endfunction

    // Two's-complement negate of the low 'width' bits of v; upper bits are
    // returned as zero. Callers zero-extend in and truncate out.
    function automatic logic [NEG_MAX_W-1:0] twos_neg(input logic [NEG_MAX_W-1:0] v,
                                                      input int unsigned width);
        logic [NEG_MAX_W-1:0] mask;
        mask = (width >= NEG_MAX_W) ? '1 : ((NEG_MAX_W'(1) << width) - NEG_MAX_W'(1));
        return (~v + NEG_MAX_W'(1)) & mask;
    endfunction

endpackage

// File: rtl/alu_md_unit_if.sv
// ---------------------------------------------------------------------------
// alu_md_unit_if
// Request/response bundle between the execute-stage control path (master)
// and the multiply/divide unit (slave).
//   start, flush, funct3, op_a, op_b : master -> unit
//   busy, done, result               : unit -> master
// ---------------------------------------------------------------------------
interface alu_md_unit_if #(
    parameter int XLEN = 32
) ();
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, funct3, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, funct3, op_a, op_b,
        output busy, done, result
    );
endinterface

// File: rtl/alu_md_unit.sv
// ---------------------------------------------------------------------------
// alu_md_unit
// Iterative RV32M multiply/divide unit, one shift-add / shift-subtract step
// per clock. Multiply and divide share one 2*XLEN shift register, one
// XLEN+2 bit adder/subtractor and one iteration counter.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-low reset
//   bus  : alu_md_unit_if slave (start/flush/funct3/op_a/op_b in,
//          busy/done/result out; all outputs registered or state-decoded)
// XLEN must be even, >= 4 and <= 64.
// ---------------------------------------------------------------------------
module alu_md_unit
    import alu_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          rst,
    alu_md_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam int AW = XLEN + 2;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;    // product / quotient negate
    logic              rneg_q, rneg_d;  // remainder negate (sign of a)
    logic [XLEN-1:0]   result_q, result_d;

    // ---------------- operand preparation (IDLE latch) ----------------
    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf;

    assign sign_a = is_signed_a(bus.funct3) & bus.op_a[XLEN-1];
    assign sign_b = is_signed_b(bus.funct3) & bus.op_b[XLEN-1];
    assign mag_a  = sign_a ? XLEN'(twos_neg(NEG_MAX_W'(bus.op_a), XLEN)) : bus.op_a;
    assign mag_b  = sign_b ? XLEN'(twos_neg(NEG_MAX_W'(bus.op_b), XLEN)) : bus.op_b;

    assign div_zero = is_div(bus.funct3) && (bus.op_b == '0);
    assign div_ovf  = is_div(bus.funct3) && is_signed_b(bus.funct3)
                      && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);

    // ---------------- shared adder / subtractor ----------------
    // Multiply: hi + (lsb ? mcand : 0).  Divide: {hi, lo msb} - mcand, where
    // a negative difference (MSB set) means "restore" and quotient bit 0.
    logic            cur_div;
    logic [AW-1:0]   add_a, add_b, sum;
    logic [2*XLEN-1:0] step_prod, fin_prod;
    logic [XLEN-1:0] quo, rem, final_res;

    assign cur_div = is_div(f3_q);
    assign add_a   = cur_div ? {1'b0, prod_q[2*XLEN-1:XLEN-1]} : {2'b00, prod_q[2*XLEN-1:XLEN]};
    assign add_b   = (cur_div || prod_q[0]) ? {2'b00, mcand_q} : '0;
    assign sum     = add_a + (cur_div ? ~add_b : add_b) + AW'(cur_div);

    always_comb begin
        if (cur_div) begin
            // On restore the shifted partial remainder is below the divisor,
            // so dropping the old hi MSB loses nothing.
            if (sum[AW-1]) step_prod = {prod_q[2*XLEN-2:0], 1'b0};
            else           step_prod = {sum[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        end else begin
            step_prod = {sum[XLEN:0], prod_q[XLEN-1:1]};
        end
    end

    // Sign correction applied to the last iteration's value as it enters DONE.
    assign fin_prod = neg_q ? (2*XLEN)'(twos_neg(NEG_MAX_W'(step_prod), 2*XLEN)) : step_prod;
    assign quo = neg_q  ? XLEN'(twos_neg(NEG_MAX_W'(step_prod[XLEN-1:0]), XLEN))
                        : step_prod[XLEN-1:0];
    assign rem = rneg_q ? XLEN'(twos_neg(NEG_MAX_W'(step_prod[2*XLEN-1:XLEN]), XLEN))
                        : step_prod[2*XLEN-1:XLEN];
    assign final_res = cur_div ? (is_rem(f3_q) ? rem : quo)
                               : (ret_high(f3_q) ? fin_prod[2*XLEN-1:XLEN] : fin_prod[XLEN-1:0]);

    // ---------------- control ----------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    f3_d   = bus.funct3;
                    neg_d  = sign_a ^ sign_b;
                    rneg_d = sign_a;
                    cnt_d  = '0;
                    if (is_div(bus.funct3)) begin
                        prod_d  = {{XLEN{1'b0}}, mag_a};
                        mcand_d = mag_b;
                    end else begin
                        prod_d  = {{XLEN{1'b0}}, mag_b};
                        mcand_d = mag_a;
                    end
                    // Zero divisor is checked first: it wins over overflow.
                    if (div_zero) begin
                        result_d = is_rem(bus.funct3) ? bus.op_a : '1;
                        state_d  = ST_DONE;
                    end else if (div_ovf) begin
                        result_d = is_rem(bus.funct3) ? '0 : bus.op_a;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                prod_d = step_prod;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN - 1)) begin
                    result_d = final_res;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (bus.flush) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_alu_md_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_md_unit
// Self-checking bench for alu_md_unit (XLEN=32): directed cases for the
// handshake, special cases, start-while-busy, flush and reset, followed by
// randomized operations checked against a 64-bit arithmetic reference.
// ---------------------------------------------------------------------------
module tb_alu_md_unit;
    localparam int XLEN = 32;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_md_unit_if #(.XLEN(XLEN)) bus();

    alu_md_unit #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // Called #1 after a rising edge in an IDLE cycle; returns #1 after the
    // edge that follows the DONE cycle.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        bit busy_ok;
        busy_ok = 1'b1;
        lat = 0;
        res = '0;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.done) begin
                lat = c;
                res = bus.result;
                break;
            end
            @(posedge clk); #1;
        end
        check("busy_during_op", 32'(busy_ok), 32'd1);
        if (lat != 0) begin
            @(posedge clk); #1;
            check("done_pulse_width", 32'(bus.done), 32'd0);
            check("busy_after_done", 32'(bus.busy), 32'd0);
        end
        $display("op f3=%0d a=%08h b=%08h result=%08h lat=%0d", f3, a, b, res, lat);
    endtask

    task automatic dir(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int          lat;
        do_op(f3, a, b, res, lat);
        check({tag, "_result"}, res, exp);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return MIN_NEG;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] res;
        int          lat;
        int          n_done, done_c, busy_n;

        rst        = 1'b0;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = 3'd0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", bus.result, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // ---- normal operations ----
        dir("mul_7_m3",     3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        dir("mulh_min_min", 3'd1, MIN_NEG, MIN_NEG, 32'h4000_0000, 33);
        dir("mulhu_max",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        dir("mulhsu_m1_2",  3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
        dir("div_m7_2",     3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        dir("rem_m7_2",     3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        dir("remu_max_16",  3'd7, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 33);

        // ---- special cases ----
        dir("div_by_zero",  3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        dir("remu_by_zero", 3'd7, 32'd5, 32'd0, 32'd5, 1);
        dir("div_overflow", 3'd4, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG, 1);
        dir("rem_overflow", 3'd6, MIN_NEG, 32'hFFFF_FFFF, 32'd0, 1);
        dir("rem_min_zero", 3'd6, MIN_NEG, 32'd0, MIN_NEG, 1);

        // ---- start re-asserted in cycles 5 and 33 of a MUL ----
        bus.funct3 = 3'd0;
        bus.op_a   = 32'd7;
        bus.op_b   = 32'hFFFF_FFFD;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_done = 0; done_c = 0; busy_n = 0; res = '0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                n_done++;
                if (done_c == 0) begin
                    done_c = c;
                    res    = bus.result;
                end
            end
            bus.start = (c == 5 || c == 33);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        check("restart_done_count", 32'(n_done), 32'd1);
        check("restart_done_cycle", 32'(done_c), 32'd33);
        check("restart_result", res, 32'hFFFF_FFEB);
        check("restart_busy_cycles", 32'(busy_n), 32'd33);
        $display("op restart-ignore done_count=%0d done_cycle=%0d result=%08h", n_done, done_c, res);

        // ---- flush in cycle 10 of a DIV ----
        dir("divu_7_2", 3'd5, 32'd7, 32'd2, 32'd3, 33);
        bus.funct3 = 3'd4;
        bus.op_a   = 32'd1000;
        bus.op_b   = 32'd7;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_done = 0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 11) check("flush_busy_c11", 32'(bus.busy), 32'd0);
            if (bus.done) n_done++;
            bus.flush = (c == 10);
            @(posedge clk); #1;
        end
        bus.flush = 1'b0;
        check("flush_no_done", 32'(n_done), 32'd0);
        check("flush_result_kept", bus.result, 32'd3);
        $display("op flush-div done_count=%0d result=%08h", n_done, bus.result);

        // ---- reset in cycle 10 of a DIV ----
        bus.funct3 = 3'd4;
        bus.op_a   = 32'd1000;
        bus.op_b   = 32'd7;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_done = 0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 11) check("reset_busy_c11", 32'(bus.busy), 32'd0);
            if (bus.done) n_done++;
            rst = (c == 10) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        check("reset_no_done", 32'(n_done), 32'd0);
        check("reset_result_cleared", bus.result, 32'd0);
        $display("op reset-div done_count=%0d result=%08h", n_done, bus.result);
        dir("mul_3_4", 3'd0, 32'd3, 32'd4, 32'd12, 33);

        // ---- randomized operations ----
        for (int i = 0; i < 120; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = rand_operand();
            b  = rand_operand();
            do_op(f3, a, b, res, lat);
            check("rand_result", res, ref_md(f3, a, b));
            check("rand_latency", 32'(lat), 32'(ref_lat(f3, a, b)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
